// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   - arb_state_e : arbiter state encoding (IDLE=0, INST=1, DATA=2)
//   - SIZE_B/H/W  : transfer size codes driven on mem_size
//   - KSEG_MASK, CONFREG_HI, CONFREG_MAP_HI : address translation constants
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // kseg0/kseg1 fold onto physical space by dropping the top three bits
  localparam logic [31:0] KSEG_MASK      = 32'h1fff_ffff;
  // confreg window seen by the data side only
  localparam logic [15:0] CONFREG_HI     = 16'hbfaf;
  localparam logic [15:0] CONFREG_MAP_HI = 16'h1faf;

endpackage

// File: rtl/mem_addr_map.sv
// mem_addr_map: combinational virtual-to-physical address fold applied when
// a request is latched. Only instantiated when MEM_ARB_ADDR_MAP_EN is defined.
//   addr_i    : requester address
//   is_data_i : 1 = data side (enables the confreg window remap)
//   addr_o    : translated address
module mem_addr_map
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              is_data_i,
  output logic [ADDR_W-1:0] addr_o
);

  always_comb begin
    addr_o = addr_i;
    // the confreg window takes priority over the generic kseg fold
    if (is_data_i && (addr_i[ADDR_W-1 -: 16] == CONFREG_HI)) begin
      addr_o = {CONFREG_MAP_HI, addr_i[ADDR_W-17:0]};
    end else if (addr_i[ADDR_W-1]) begin
      addr_o = addr_i & ADDR_W'(KSEG_MASK);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single AXI-side memory port between
// instruction fetch (i_*) and data load/store (d_*).
//   clk, rst          : clock, synchronous active-high reset
//   i_req/i_addr      : fetch request (level) and PC
//   i_ready/i_rdata   : fetch done pulse, last fetched word (held)
//   d_req/d_write/d_size/d_sel/d_addr/d_wdata : load/store request
//   d_ready/d_rdata   : data done pulse, last load word (held)
//   flush             : exception flush, cancels the data side only
//   mem_*             : transaction to the AXI interface, mem_flush cancels
//   mem_ready/mem_data: transaction complete + read data
//   stall_if/stall_mem: pipeline stall requests
// Build option: define MEM_ARB_ADDR_MAP_EN to translate addresses at grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [1:0]        d_size,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              flush,
  output logic              mem_access,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_st_data,
  output logic              mem_flush,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_e        state_q, state_d;
  logic              last_data_q, last_data_d;  // last completed grant was data
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              d_pend, grant_data, busy;
  logic [ADDR_W-1:0] req_addr, map_addr;

  // a flush in IDLE hides the data request for that cycle
  assign d_pend     = d_req & ~flush;
  // data wins a tie unless it also won last time
  assign grant_data = d_pend & ~(i_req & last_data_q);
  assign req_addr   = grant_data ? d_addr : i_addr;

`ifdef MEM_ARB_ADDR_MAP_EN
  mem_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .addr_i    (req_addr),
    .is_data_i (grant_data),
    .addr_o    (map_addr)
  );
`else
  assign map_addr = req_addr;
`endif

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    addr_d      = addr_q;
    write_d     = write_q;
    size_d      = size_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req | d_pend) begin
          state_d = grant_data ? DATA : INST;
          addr_d  = map_addr;
          write_d = grant_data & d_write;
          size_d  = grant_data ? d_size : SIZE_W;
          sel_d   = grant_data ? d_sel : 4'b1111;
          wdata_d = grant_data ? d_wdata : '0;
        end
      end
      INST: begin
        if (mem_ready) begin
          state_d     = IDLE;
          i_rdata_d   = mem_data;
          last_data_d = 1'b0;
        end
      end
      DATA: begin
        // flush beats a coincident mem_ready: the access is dropped
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d     = IDLE;
          d_rdata_d   = mem_data;
          last_data_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // outputs are forced quiet while rst is high so an abandoned
  // transaction never produces a ready pulse
  assign busy        = (state_q != IDLE) & ~rst;
  assign mem_access  = busy;
  assign mem_write   = busy & write_q;
  assign mem_size    = busy ? size_q  : '0;
  assign mem_sel     = busy ? sel_q   : '0;
  assign mem_a       = busy ? addr_q  : '0;
  assign mem_st_data = busy ? wdata_q : '0;
  assign mem_flush   = (state_q == DATA) & flush & ~rst;
  assign i_ready     = (state_q == INST) & mem_ready & ~rst;
  assign d_ready     = (state_q == DATA) & mem_ready & ~flush & ~rst;
  assign i_rdata     = rst ? '0 : i_rdata_q;
  assign d_rdata     = rst ? '0 : d_rdata_q;
  assign stall_if    = i_req & ~i_ready;
  assign stall_mem   = d_req & ~d_ready & ~flush;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_write = 1'b0;
  logic [1:0]    d_size = '0;
  logic [3:0]    d_sel = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          flush = 1'b0;
  logic          mem_access, mem_write, mem_flush;
  logic [1:0]    mem_size;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_st_data;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .flush(flush),
    .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
    .mem_sel(mem_sel), .mem_a(mem_a), .mem_st_data(mem_st_data),
    .mem_flush(mem_flush), .mem_ready(mem_ready), .mem_data(mem_data),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  // reference model state
  bit          m_last_data = 1'b0;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;
  // memory model control: 0 random, 1 stall, 2 ready now, 3 fixed 3-cycle wait
  int          bfm_mode = 0;
  logic [31:0] bfm_fixed = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] map_addr(input logic [31:0] a, input bit is_data);
`ifdef MEM_ARB_ADDR_MAP_EN
    if (is_data && a[31:16] == 16'hbfaf) return {16'h1faf, a[15:0]};
    if (a[31]) return {3'b000, a[28:0]};
`endif
    return a;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'hbfc0_0000 | ($urandom & 32'hffff);
      1:       return 32'hbfaf_0000 | ($urandom & 32'hffff);
      2:       return 32'h8000_0000 | ($urandom & 32'hfffff);
      default: return $urandom;
    endcase
  endfunction

  // memory responder
  initial begin : mem_bfm
    int cnt;
    cnt = -1;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (bfm_mode == 2) begin
        mem_ready = 1'b1;
        mem_data  = $urandom;
      end else if (bfm_mode != 1 && mem_access) begin
        if (cnt < 0) cnt = (bfm_mode == 3) ? 3 : int'($urandom_range(0, 3));
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_data  = (bfm_mode == 3) ? bfm_fixed : $urandom;
          cnt = -1;
        end else begin
          cnt--;
        end
      end else begin
        cnt = -1;
        // stray mem_ready while idle must be ignored
        if (bfm_mode == 0 && $urandom_range(0, 3) == 0) begin
          mem_ready = 1'b1;
          mem_data  = $urandom;
        end
      end
    end
  end

  // monitor / scoreboard
  bit   in_txn = 1'b0;
  bit   ended = 1'b0;
  bit   was_ended, exp_ir, exp_dr, exp_fl;
  txn_t cur;

  always @(negedge clk) begin
    was_ended = ended;
    ended  = 1'b0;
    exp_ir = 1'b0;
    exp_dr = 1'b0;
    exp_fl = 1'b0;
    if (rst) begin
      chk("rst_mem_access", mem_access, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_flush", mem_flush, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      in_txn = 1'b0;
      ended  = 1'b1;
      m_i_rdata = '0;
      m_d_rdata = '0;
      m_last_data = 1'b0;
    end else begin
      if (!in_txn && mem_access) begin
        if (was_ended) chk("idle_gap_mem_access", mem_access, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: mem_a %h with no request outstanding", mem_a);
        end else begin
          cur = exp_q.pop_front();
          in_txn = 1'b1;
        end
      end
      if (in_txn) begin
        chk("mem_access", mem_access, 1);
        chk("mem_a", mem_a, cur.addr);
        chk("mem_write", mem_write, cur.write);
        chk("mem_size", mem_size, cur.size);
        chk("mem_sel", mem_sel, cur.sel);
        if (cur.is_data) chk("mem_st_data", mem_st_data, cur.wdata);
        exp_fl = cur.is_data && flush;
        exp_ir = !cur.is_data && mem_ready;
        exp_dr = cur.is_data && mem_ready && !flush;
      end
      chk("mem_flush", mem_flush, exp_fl);
      chk("i_ready", i_ready, exp_ir);
      chk("d_ready", d_ready, exp_dr);
      chk("i_rdata", i_rdata, m_i_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
      if (exp_fl) begin
        in_txn = 1'b0;
        ended  = 1'b1;
      end else if (exp_ir) begin
        m_i_rdata = mem_data;
        m_last_data = 1'b0;
        in_txn = 1'b0;
        ended  = 1'b1;
      end else if (exp_dr) begin
        m_d_rdata = mem_data;
        m_last_data = 1'b1;
        in_txn = 1'b0;
        ended  = 1'b1;
      end
    end
    chk("stall_if", stall_if, i_req && !exp_ir);
    chk("stall_mem", stall_mem, d_req && !exp_dr && !flush);
  end

  // issue fetch and/or data requests, hold until each completes
  task automatic run_reqs(input bit do_i, input bit do_d);
    bit   pi, pd, win_d, serve_d;
    int   guard;
    txn_t ti, td;
    pi = do_i;
    pd = do_d;
    ti = '{1'b0, map_addr(i_addr, 1'b0), 1'b0, 2'd2, 4'hf, 32'h0};
    td = '{1'b1, map_addr(d_addr, 1'b1), d_write, d_size, d_sel, d_wdata};
    win_d = pd && !(pi && m_last_data);
    if (win_d) begin
      exp_q.push_back(td);
      if (pi) exp_q.push_back(ti);
    end else begin
      exp_q.push_back(ti);
      if (pd) exp_q.push_back(td);
    end
    @(posedge clk); #1;
    i_req = pi;
    d_req = pd;
    guard = 0;
    while ((pi || pd) && guard < 100) begin
      #1;
      serve_d = win_d ? pd : !pi;
      if (pi && i_ready) pi = 1'b0;
      if (pd && d_ready) pd = 1'b0;
      // disturb the side in service; the latched copy must not move
      if (mem_access) begin
        if (serve_d && pd) begin
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_sel   = 4'($urandom);
          d_size  = 2'($urandom);
          d_write = 1'($urandom);
        end else if (!serve_d && pi) begin
          i_addr = $urandom;
        end
      end
      @(posedge clk); #1;
      i_req = pi;
      d_req = pd;
      guard++;
    end
    chk("req_complete_in_time", guard < 100, 1);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // data access cancelled by flush once it is in service
  task automatic run_flush(input bit coincide);
    int guard;
    bfm_mode = 1;
    exp_q.push_back('{1'b1, map_addr(d_addr, 1'b1), d_write, d_size, d_sel, d_wdata});
    @(posedge clk); #1 d_req = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); #2;
      guard++;
    end while (!mem_access && guard < 20);
    chk("flush_grant_in_time", guard < 20, 1);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #2;
    end
    if (coincide) bfm_mode = 2;
    @(posedge clk); #2;
    flush = 1'b1;
    bfm_mode = 1;
    @(posedge clk); #1;
    flush = 1'b0;
    d_req = 1'b0;
    bfm_mode = 0;
  endtask

  // flush in IDLE hides a data request for that cycle
  task automatic run_flush_idle();
    @(posedge clk); #1;
    d_req = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int guard;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // fetch with a 3-cycle memory wait
    bfm_fixed = 32'h2401_0001;
    bfm_mode  = 3;
    i_addr    = 32'hbfc0_0000;
    run_reqs(1'b1, 1'b0);
    bfm_mode  = 0;
    @(negedge clk);
    chk("fetch_i_rdata", i_rdata, 32'h2401_0001);

    // tie with last grant INST: data first
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    d_write = 1'b0; d_size = 2'd2; d_sel = 4'hf; d_wdata = 32'h0;
    run_reqs(1'b1, 1'b1);

    // half-word store into the confreg window
    d_write = 1'b1; d_sel = 4'b0011; d_size = 2'd1;
    d_addr = 32'hbfaf_0010; d_wdata = 32'h0000_dead;
    run_reqs(1'b0, 1'b1);

    // tie right after a data grant: fetch first
    i_addr = 32'h0000_0300; d_addr = 32'h0000_0400; d_write = 1'b0;
    run_reqs(1'b1, 1'b1);

    d_addr = rand_addr();
    run_flush(1'b1);
    run_flush(1'b0);
    run_flush_idle();

    for (int n = 0; n < 150; n++) begin
      i_addr  = rand_addr();
      d_addr  = rand_addr();
      d_write = 1'($urandom);
      d_size  = 2'($urandom_range(0, 2));
      d_sel   = 4'($urandom);
      d_wdata = $urandom;
      case ($urandom_range(0, 6))
        0, 1:    run_reqs(1'b1, 1'b0);
        2, 3:    run_reqs(1'b0, 1'b1);
        4, 5:    run_reqs(1'b1, 1'b1);
        default: begin
          if ($urandom_range(0, 1) == 1) run_flush(1'($urandom));
          else run_flush_idle();
        end
      endcase
    end

    // reset in the middle of a fetch, with mem_ready in the reset cycle
    bfm_mode = 1;
    i_addr = rand_addr();
    exp_q.push_back('{1'b0, map_addr(i_addr, 1'b0), 1'b0, 2'd2, 4'hf, 32'h0});
    @(posedge clk); #1 i_req = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); #2;
      guard++;
    end while (!mem_access && guard < 20);
    chk("rst_test_grant_in_time", guard < 20, 1);
    bfm_mode = 2;
    @(posedge clk); #1 rst = 1'b1;
    #1 bfm_mode = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_req = 1'b0;
    bfm_mode = 0;
    @(negedge clk);
    chk("post_rst_mem_access", mem_access, 0);
    chk("post_rst_i_rdata", i_rdata, 0);
    chk("post_rst_d_rdata", d_rdata, 0);

    repeat (4) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single memory port of the AXI interface between instruction fetch and data load/store in the CPU top. Each side gets a request/ready handshake. Requests are latched at grant and held stable for the whole transaction. Returned data is held in a per-side register. A data-side flush from exceptions cancels the pending or in-flight data access. It replaces the ad-hoc per-cycle select register in the top level.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_ready
- i_addr  in  ADDR_W  fetch address (PC)
- i_ready  out  1  one-cycle pulse: fetch complete
- i_rdata  out  DATA_W  last fetched word, held
- d_req  in  1  load/store request, level, held until d_ready or flush
- d_write  in  1  1 = store
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_sel  in  4  byte strobes
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  last load word, held
- flush  in  1  exception flush (cancels data side only)
- mem_access  out  1  transaction request to AXI interface
- mem_write  out  1  write enable
- mem_size  out  2  transfer size
- mem_sel  out  4  byte strobes
- mem_a  out  ADDR_W  address
- mem_st_data  out  DATA_W  write data
- mem_flush  out  1  cancel in-flight access
- mem_ready  in  1  transaction complete
- mem_data  in  DATA_W  read data, valid with mem_ready
- stall_if  out  1  i_req & ~i_ready
- stall_mem  out  1  d_req & ~d_ready & ~flush

## Operation
- States: IDLE, INST, DATA.
- IDLE, arbitration:
  - both requests pending: d_req wins, unless last_grant == DATA, in which case i_req wins (anti-starvation).
  - single request pending: that request wins.
  - the winner's address, size, sel, write and wdata are latched into hold registers; next state is INST or DATA.
- INST/DATA:
  - mem_access = 1; mem_* driven from the hold registers only.
  - Inst side always drives mem_write=0, mem_size=2, mem_sel=4'b1111.
  - On mem_ready: latch mem_data into i_rdata or d_rdata, pulse i_ready or d_ready, update last_grant, return to IDLE.
- Flush:
  - In DATA: mem_flush=1 for that cycle, go to IDLE, no d_ready, d_rdata unchanged.
  - In IDLE: d_req is ignored that cycle.
  - Never affects INST.
- Reset:
  - state=IDLE, last_grant=INST, i_rdata=d_rdata=0.
  - All outputs 0, except stall_if/stall_mem, which follow their equations.
  - Reset mid-transaction abandons it with no ready pulse.

## Timing
- Grant is registered. A request seen in IDLE at cycle N asserts mem_access at N+1.
- Earliest ready: mem_ready at N+1 gives i_ready/d_ready at N+1. The held *_rdata is valid from N+2.
- mem_ready and flush in the same DATA cycle: flush wins, no d_ready, no rdata update.
- mem_ready outside INST/DATA is ignored.
- Minimum one IDLE cycle between transactions. Back-to-back throughput is 1 access per 2 cycles with zero-wait memory.
- Requester inputs may change after grant without effect.

## Configuration
- MEM_ARB_ADDR_MAP_EN defined: address translation is applied when a request is latched.
  - Addresses with bit 31 set map to {3'b0, a[28:0]}.
  - Data addresses with [31:16]==16'hbfaf map to {16'h1faf, a[15:0]}.
- Undefined: addresses pass through unchanged.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE=0, INST=1, DATA=2)
  - size constants SIZE_B/H/W
  - KSEG_MASK and CONFREG_HI constants
- One sub-module, `mem_addr_map`: combinational translation, instantiated only under MEM_ARB_ADDR_MAP_EN.

## Test plan
- Fetch only: i_req=1, i_addr=0xbfc00000, mem_ready 3 cycles after mem_access, mem_data=0x24010001 -> mem_a=0x1fc00000 (macro on), i_ready pulses once, i_rdata=0x24010001.
- Both pending in IDLE with last_grant=INST -> DATA granted first, then INST. Next simultaneous pair -> INST first.
- Store: d_write=1, d_sel=4'b0011, d_size=1, d_addr=0xbfaf0010, d_wdata=0xdead -> mem_a=0x1faf0010, mem_sel=0011, mem_write=1, d_ready after mem_ready.
- Flush in DATA coincident with mem_ready -> mem_flush=1, no d_ready, d_rdata keeps its old value, state returns to IDLE.
- Inputs changed after grant (i_addr 0x100 -> 0x200) -> mem_a stays 0x100 until mem_ready.
- rst asserted in INST -> next cycle IDLE, mem_access=0, no i_ready, rdata registers=0.
